// File: rtl/nn_agent_stepper.sv
// nn_agent_stepper
//   Agent-side partner of neural_network. On each accepted step it reads the
//   six grid cells around the agent (front, front-left, left, front-right,
//   right, far front) from an obstacle RAM. It presents them as sensor bits
//   a..f and samples the network's dir decision. It then turns and moves the
//   agent by one cell, reporting a crash when the target cell is blocked.
//
// Ports
//   clk, rst          : rising-edge clock, synchronous active-high reset
//   step              : one-cycle request, accepted only while idle
//   rd_en, rd_addr    : registered obstacle RAM read (addr = y*GRID_W + x)
//   rd_data           : obstacle bit, valid the cycle after rd_en
//   a..f              : registered sensor bits (1 = blocked or off-grid)
//   sens_valid        : sensors stable, dir sampled this cycle
//   dir               : 00 straight, 01 left, 10 right, 11 hold
//   pos_x, pos_y      : agent position
//   heading           : 0=N, 1=E, 2=S, 3=W
//   busy, done, crash : step in progress / completion pulse / blocked move
//
// Handshake: step has no ready. It is taken only in IDLE and dropped
// otherwise, so the caller watches busy/done and pulses step again after done.
// No request is queued.

module nn_agent_stepper #(
  parameter int GRID_W     = 16,
  parameter int GRID_H     = 16,
  parameter int X_W        = 4,
  parameter int Y_W        = 4,
  parameter int ADDR_W     = 8,
  parameter int START_X    = 0,
  parameter int START_Y    = 0,
  parameter int START_HEAD = 1
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              step,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic              rd_data,
  output logic              a,
  output logic              b,
  output logic              c,
  output logic              d,
  output logic              e,
  output logic              f,
  output logic              sens_valid,
  input  logic [1:0]        dir,
  output logic [X_W-1:0]    pos_x,
  output logic [Y_W-1:0]    pos_y,
  output logic [1:0]        heading,
  output logic              busy,
  output logic              done,
  output logic              crash
);

  typedef enum logic [3:0] {
    S_IDLE, S_Q0, S_Q1, S_Q2, S_Q3, S_Q4, S_Q5, S_WAIT, S_DECIDE, S_MOVE
  } state_t;

  state_t            state_q, state_d;
  logic [X_W-1:0]    pos_x_q, pos_x_d;
  logic [Y_W-1:0]    pos_y_q, pos_y_d;
  logic [1:0]        head_q, head_d;
  logic [1:0]        dir_q, dir_d;
  logic [5:0]        sens_q, sens_d;   // bit k = sensor k (a = bit 0)
  logic              rd_en_q, rd_en_d;
  logic [ADDR_W-1:0] rd_addr_q, rd_addr_d;
  logic              hit_prev_q, hit_prev_d;  // previous slot issued a real read

  logic       issue;
  logic [2:0] slot;
  logic       in_grid;
  logic       cap;
  logic [1:0] mh;
  logic       go;
  logic       blocked;
  int         fx, fy, lx, ly, ox, oy, cx, cy;

  function automatic int dx_of(input logic [1:0] h);
    case (h)
      2'd1:    return 1;
      2'd3:    return -1;
      default: return 0;
    endcase
  endfunction

  function automatic int dy_of(input logic [1:0] h);
    case (h)
      2'd0:    return -1;
      2'd2:    return 1;
      default: return 0;
    endcase
  endfunction

  // The read registered on this edge belongs to the slot being entered next.
  always_comb begin
    issue = 1'b0;
    slot  = 3'd0;
    case (state_q)
      S_IDLE: begin issue = step; slot = 3'd0; end
      S_Q0:   begin issue = 1'b1; slot = 3'd1; end
      S_Q1:   begin issue = 1'b1; slot = 3'd2; end
      S_Q2:   begin issue = 1'b1; slot = 3'd3; end
      S_Q3:   begin issue = 1'b1; slot = 3'd4; end
      S_Q4:   begin issue = 1'b1; slot = 3'd5; end
      default: ;
    endcase
  end

  // Cell geometry: offsets built from the forward and left unit vectors.
  always_comb begin
    fx = dx_of(head_q);
    fy = dy_of(head_q);
    lx = dx_of(head_q - 2'd1);
    ly = dy_of(head_q - 2'd1);
    ox = 0;
    oy = 0;
    case (slot)
      3'd0:    begin ox = fx;      oy = fy;      end
      3'd1:    begin ox = fx + lx; oy = fy + ly; end
      3'd2:    begin ox = lx;      oy = ly;      end
      3'd3:    begin ox = fx - lx; oy = fy - ly; end
      3'd4:    begin ox = -lx;     oy = -ly;     end
      default: begin ox = 2 * fx;  oy = 2 * fy;  end
    endcase
    cx = int'(pos_x_q) + ox;
    cy = int'(pos_y_q) + oy;
    in_grid = (cx >= 0) && (cx < GRID_W) && (cy >= 0) && (cy < GRID_H);
  end

  always_comb begin
    state_d    = state_q;
    pos_x_d    = pos_x_q;
    pos_y_d    = pos_y_q;
    head_d     = head_q;
    dir_d      = dir_q;
    sens_d     = sens_q;
    rd_en_d    = issue && in_grid;
    rd_addr_d  = rd_en_d ? ADDR_W'(cy * GRID_W + cx) : '0;
    hit_prev_d = rd_en_q;
    busy       = (state_q != S_IDLE);
    sens_valid = (state_q == S_DECIDE);
    done       = 1'b0;
    crash      = 1'b0;
    mh         = head_q;
    go         = 1'b0;
    blocked    = 1'b0;
    // Off-grid slots issued no read, so they capture a forced 1.
    cap        = hit_prev_q ? rd_data : 1'b1;

    case (state_q)
      S_IDLE:   if (step) state_d = S_Q0;
      S_Q0:     state_d = S_Q1;
      S_Q1:     begin state_d = S_Q2;     sens_d[0] = cap; end
      S_Q2:     begin state_d = S_Q3;     sens_d[1] = cap; end
      S_Q3:     begin state_d = S_Q4;     sens_d[2] = cap; end
      S_Q4:     begin state_d = S_Q5;     sens_d[3] = cap; end
      S_Q5:     begin state_d = S_WAIT;   sens_d[4] = cap; end
      S_WAIT:   begin state_d = S_DECIDE; sens_d[5] = cap; end
      S_DECIDE: begin state_d = S_MOVE;   dir_d = dir;     end
      S_MOVE: begin
        state_d = S_IDLE;
        done    = 1'b1;
        // The front/left/right sensors already cover the target cell,
        // including the off-grid case.
        case (dir_q)
          2'b00:   begin mh = head_q;        go = 1'b1; blocked = sens_q[0]; end
          2'b01:   begin mh = head_q - 2'd1; go = 1'b1; blocked = sens_q[2]; end
          2'b10:   begin mh = head_q + 2'd1; go = 1'b1; blocked = sens_q[4]; end
          default: begin mh = head_q;        go = 1'b0; blocked = 1'b0;      end
        endcase
        head_d = mh;
        crash  = go && blocked;
        if (go && !blocked) begin
          pos_x_d = pos_x_q + X_W'(dx_of(mh));
          pos_y_d = pos_y_q + Y_W'(dy_of(mh));
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      pos_x_q    <= X_W'(START_X);
      pos_y_q    <= Y_W'(START_Y);
      head_q     <= 2'(START_HEAD);
      dir_q      <= 2'b00;
      sens_q     <= 6'b0;
      rd_en_q    <= 1'b0;
      rd_addr_q  <= '0;
      hit_prev_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      pos_x_q    <= pos_x_d;
      pos_y_q    <= pos_y_d;
      head_q     <= head_d;
      dir_q      <= dir_d;
      sens_q     <= sens_d;
      rd_en_q    <= rd_en_d;
      rd_addr_q  <= rd_addr_d;
      hit_prev_q <= hit_prev_d;
    end
  end

  assign rd_en   = rd_en_q;
  assign rd_addr = rd_addr_q;
  assign pos_x   = pos_x_q;
  assign pos_y   = pos_y_q;
  assign heading = head_q;
  assign a       = sens_q[0];
  assign b       = sens_q[1];
  assign c       = sens_q[2];
  assign d       = sens_q[3];
  assign e       = sens_q[4];
  assign f       = sens_q[5];

endmodule
